// File: rtl/mips_memory_responder.sv
// Memory-side responder for the multi-cycle MIPS bus.
// Provides a unified word RAM, a byte-stream program loader, processor reset
// control, and two memory-mapped I/O words (output register, run-cycle counter).
module mips_memory_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter logic [31:0] IO_OUT_ADDR = 32'hFFFF_FFF0,
    parameter logic [31:0] IO_CYC_ADDR = 32'hFFFF_FFF4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic        mem_write,
    output logic [31:0] data_in,
    output logic        cpu_reset,
    input  logic        load_start,
    input  logic        run_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [31:0] io_out,
    output logic        running
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [31:0]           ram [DEPTH];
    logic [ADDR_WIDTH-1:0] word_ptr;
    logic [1:0]            byte_cnt;
    logic [31:0]           asm_word;
    logic [31:0]           merged_word;
    logic [31:0]           cyc_cnt;
    logic                  accept;
    logic                  word_done;
    logic                  enter_load;
    logic                  in_run;
    logic                  is_out;
    logic                  is_cyc;
    logic                  is_ram;
    logic [ADDR_WIDTH-1:0] cpu_idx;
    logic                  cpu_ram_we;
    logic                  cpu_out_we;

    // Loader handshake and processor address decode
    always_comb begin
        accept     = load_valid && load_ready;
        word_done  = accept && ((byte_cnt == 2'd3) || load_last);
        enter_load = (state != S_LOAD) && (next_state == S_LOAD);
        in_run     = (state == S_RUN);
        is_out     = (address == IO_OUT_ADDR);
        is_cyc     = (address == IO_CYC_ADDR);
        is_ram     = !is_out && !is_cyc && (address[31:28] != 4'hF);
        cpu_idx    = address[ADDR_WIDTH+1:2];
        cpu_ram_we = in_run && mem_write && is_ram && !reset;
        cpu_out_we = in_run && mem_write && is_out;
    end

    // Next-state selection; load_start has priority over run_start
    always_comb begin
        next_state = state;
        case (state)
            S_HOLD: begin
                if (load_start) begin
                    next_state = S_LOAD;
                end else if (run_start) begin
                    next_state = S_RUN;
                end
            end
            S_LOAD: begin
                if (accept && load_last) begin
                    next_state = S_HOLD;
                end
            end
            S_RUN: begin
                if (load_start) begin
                    next_state = S_LOAD;
                end
            end
            default: next_state = S_HOLD;
        endcase
    end

    // State register and the status outputs that follow it
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_HOLD;
            cpu_reset  <= 1'b1;
            load_ready <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= next_state;
            cpu_reset  <= (next_state != S_RUN);
            load_ready <= (next_state == S_LOAD);
            running    <= (next_state == S_RUN);
        end
    end

    // Little-endian merge of the incoming byte into the word being assembled
    always_comb begin
        merged_word = asm_word;
        case (byte_cnt)
            2'd0:    merged_word[7:0]   = load_data;
            2'd1:    merged_word[15:8]  = load_data;
            2'd2:    merged_word[23:16] = load_data;
            default: merged_word[31:24] = load_data;
        endcase
    end

    // Loader pointer, byte count and assembly register
    always_ff @(posedge clock) begin
        if (reset || enter_load) begin
            word_ptr <= '0;
            byte_cnt <= 2'd0;
            asm_word <= 32'd0;
        end else if (word_done) begin
            word_ptr <= word_ptr + ADDR_WIDTH'(1);
            byte_cnt <= 2'd0;
            asm_word <= 32'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_word <= merged_word;
        end
    end

    // Run-cycle counter, cleared whenever a new load begins
    always_ff @(posedge clock) begin
        if (reset || enter_load) begin
            cyc_cnt <= 32'd0;
        end else if (in_run) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    // Output register
    always_ff @(posedge clock) begin
        if (reset) begin
            io_out <= 32'd0;
        end else if (cpu_out_we) begin
            io_out <= data_out;
        end
    end

    // Word RAM; loader and processor writes are exclusive by state
    always_ff @(posedge clock) begin
        if (word_done && !reset) begin
            ram[word_ptr] <= merged_word;
        end else if (cpu_ram_we) begin
            ram[cpu_idx] <= data_out;
        end
    end

    // Combinational read path, only live while the processor runs
    always_comb begin
        data_in = 32'd0;
        if (in_run) begin
            if (is_out) begin
                data_in = io_out;
            end else if (is_cyc) begin
                data_in = cyc_cnt;
            end else if (is_ram) begin
                data_in = ram[cpu_idx];
            end
        end
    end

endmodule

// File: doc/mips_memory_responder.md
Name: mips_memory_responder

Overview:
- Memory-side end of the multi-cycle MIPS processor bus: a unified instruction/data word RAM that answers `address`, `data_out` and `mem_write`, and returns `data_in`.
- Adds a byte-stream program loader with a valid/ready handshake.
- Holds the processor in reset while a program is loaded.
- Exposes two memory-mapped I/O words: an output register and a run-cycle counter.

Parameters:
- ADDR_WIDTH, 8, RAM word-index width; depth is 2^ADDR_WIDTH 32-bit words.
- IO_OUT_ADDR, 32'hFFFF_FFF0, byte address of the output register (read/write).
- IO_CYC_ADDR, 32'hFFFF_FFF4, byte address of the run-cycle counter (read-only).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  32  processor byte address.
- data_out  in  32  processor write data.
- mem_write  in  1  processor write strobe.
- data_in  out  32  read data returned to the processor (combinational).
- cpu_reset  out  1  registered reset driven to the processor core.
- load_start  in  1  request to enter load mode.
- run_start  in  1  request to release the processor.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte.
- load_last  in  1  marks the final byte of the image; qualified by load_valid.
- load_ready  out  1  responder accepts a byte this cycle.
- io_out  out  32  output register contents.
- running  out  1  high in RUN state.

Behaviour:
- **Reset.** State goes to HOLD. Output and internal values on reset:
  - cpu_reset=1, load_ready=0, running=0, io_out=0.
  - Cycle counter=0, byte count=0, word pointer=0, assembly register=0.
  - RAM contents are not reset.
- **States.** HOLD, LOAD, RUN.
  - HOLD: load_start -> LOAD; otherwise run_start -> RUN. If both are asserted, load_start wins.
  - LOAD: leaves only on an accepted byte with load_last=1 -> HOLD. load_start/run_start are ignored here.
  - RUN: load_start -> LOAD; run_start is ignored.
- **Registered outputs.**
  - cpu_reset is registered: equals 1 in every cycle whose state is not RUN, and deasserts the cycle the state becomes RUN.
  - running equals (state==RUN).
- **Load mode.**
  - Entering LOAD clears: word pointer, byte count, assembly register, cycle counter.
  - load_ready=1 exactly while state==LOAD. A byte is accepted when load_valid && load_ready.
  - Bytes are little-endian: byte 0 goes to bits [7:0], byte 3 to bits [31:24].
  - On acceptance of the 4th byte, the assembled word (with the current byte merged) is written to RAM[word pointer] in that same edge. The pointer then increments and the byte count returns to 0.
  - load_last on a partial word: zero-pad the unfilled upper bytes and write in the same edge.
  - The word pointer wraps from 2^ADDR_WIDTH-1 to 0 without error.
- **Processor access.** Honoured only in RUN; in HOLD/LOAD, processor writes are dropped and data_in=0.
  - Address decode uses the full 32-bit compare for IO_OUT_ADDR and IO_CYC_ADDR.
  - Any other address with address[31:28]==4'hF is unmapped: reads return 0 and writes are dropped.
  - All remaining addresses are RAM. Word index = address[ADDR_WIDTH+1:2]. address[1:0] and the upper bits are ignored, so RAM aliases.
  - Reads are combinational (same-cycle data_in), as required by the multi-cycle fetch/load states.
  - Writes occur at the clock edge where mem_write=1; a read of the same word in that cycle returns the old value.
- **I/O registers.**
  - Write to IO_OUT_ADDR: io_out <= data_out. Read returns io_out.
  - Cycle counter increments every cycle in RUN and wraps at 2^32. Read of IO_CYC_ADDR returns the pre-increment value; writes to it are dropped.
- **Reset mid-operation.**
  - Reset during LOAD abandons the partial word; RAM words already written remain.
  - Reset during RUN returns to HOLD with io_out=0.

Test Plan:
- Reset -> cpu_reset=1, load_ready=0, io_out=0, running=0; data_in=0 for address 0.
- load_start, then stream bytes 13,00,08,20 then EF,BE,AD,DE with load_last on the final byte; then run_start:
  - RAM[0]=32'h2008_0013 and RAM[1]=32'hDEAD_BEEF.
  - Back in HOLD; cpu_reset drops one cycle after run_start.
  - In RUN, address=4 gives data_in=32'hDEAD_BEEF.
- Partial word: bytes AA,BB with load_last -> RAM[0]=32'h0000_BBAA. Also, load_valid held with gaps of load_valid=0 -> no extra writes.
- In RUN:
  - mem_write at address 32'h40 with data 32'h1234_5678 -> the next-cycle read returns 32'h1234_5678; address 32'h440 (alias when ADDR_WIDTH=8) returns the same.
  - Write 32'hA5 to 32'hFFFF_FFF0 -> io_out=32'hA5.
  - Write to 32'hFFFF_FFE0 -> no change anywhere.
- Cycle counter: run_start then 10 cycles -> read 32'hFFFF_FFF4 gives 10. Then load_start -> counter reads 0 after returning to RUN.
- Corner cases:
  - Loading 2^ADDR_WIDTH+1 words -> pointer wraps and word 256 overwrites RAM[0].
  - Reset asserted after 2 bytes of a word -> RAM unchanged for that word, state HOLD.
  - load_start and run_start together in HOLD -> LOAD.
